// File: rtl/pwl_approx.sv
// pwl_approx: three-stage piecewise-linear evaluator downstream of the scaler.
//   y = a[seg] + ((b[seg] * frac) >>> (W-SEG_BITS)), saturated to W bits, then
//   de-normalised by the scaler's shift flags (shift_l: >>>1, shift_r: sat <<1).
//
// Ports
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   valid_i, x_scaled_i  : sample strobe and signed Q1.(W-1) normalised sample
//   shift_l_i, shift_r_i,
//   no_shift_i           : one-hot de-normalisation flags from the scaler
//   coef_we, coef_addr,
//   coef_a, coef_b       : coefficient table write port (offset a, slope b)
//   y_o, valid_o, err_o  : result, result strobe, non-one-hot flag indicator
module pwl_approx #(
  parameter int unsigned W        = 8,
  parameter int unsigned SEG_BITS = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  input  logic signed [W-1:0]        x_scaled_i,
  input  logic                       shift_l_i,
  input  logic                       shift_r_i,
  input  logic                       no_shift_i,
  input  logic                       coef_we,
  input  logic        [SEG_BITS-1:0] coef_addr,
  input  logic signed [W-1:0]        coef_a,
  input  logic signed [W-1:0]        coef_b,
  output logic signed [W-1:0]        y_o,
  output logic                       valid_o,
  output logic                       err_o
);

  localparam int unsigned FW   = W - SEG_BITS;          // fraction width
  localparam int unsigned PW   = 2 * W - SEG_BITS + 1;  // full product width
  localparam int unsigned NSEG = 1 << SEG_BITS;

  // ---------------------------------------------------------------------------
  // Coefficient table
  // ---------------------------------------------------------------------------
  logic signed [W-1:0] r_tbl_a [NSEG];
  logic signed [W-1:0] r_tbl_b [NSEG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NSEG); i++) begin
        r_tbl_a[i] <= '0;
        r_tbl_b[i] <= '0;
      end
    end else if (coef_we) begin
      r_tbl_a[coef_addr] <= coef_a;
      r_tbl_b[coef_addr] <= coef_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture sample, decode flags, read table (old contents on a
  // same-edge write, since the table updates with non-blocking semantics)
  // ---------------------------------------------------------------------------
  logic [SEG_BITS-1:0] w_seg;
  logic                w_onehot;

  assign w_seg    = x_scaled_i[W-1 -: SEG_BITS];
  assign w_onehot = ({shift_l_i, shift_r_i, no_shift_i} == 3'b100) ||
                    ({shift_l_i, shift_r_i, no_shift_i} == 3'b010) ||
                    ({shift_l_i, shift_r_i, no_shift_i} == 3'b001);

  logic signed [W-1:0]  r1_a;
  logic signed [W-1:0]  r1_b;
  logic        [FW-1:0] r1_frac;
  logic                 r1_sl;
  logic                 r1_sr;
  logic                 r1_err;
  logic                 r1_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_a     <= '0;
      r1_b     <= '0;
      r1_frac  <= '0;
      r1_sl    <= 1'b0;
      r1_sr    <= 1'b0;
      r1_err   <= 1'b0;
      r1_valid <= 1'b0;
    end else begin
      r1_a     <= r_tbl_a[w_seg];
      r1_b     <= r_tbl_b[w_seg];
      r1_frac  <= x_scaled_i[FW-1:0];
      // A bad flag set falls back to the no-shift path.
      r1_sl    <= w_onehot & shift_l_i;
      r1_sr    <= w_onehot & shift_r_i;
      r1_err   <= valid_i & ~w_onehot;
      r1_valid <= valid_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: signed slope times unsigned fraction, full width
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] w_b_ext;
  logic signed [PW-1:0] w_frac_ext;
  logic signed [PW-1:0] w_prod;

  assign w_b_ext    = PW'(r1_b);
  assign w_frac_ext = $signed(PW'({1'b0, r1_frac}));
  assign w_prod     = w_b_ext * w_frac_ext;

  logic signed [PW-1:0] r2_prod;
  logic signed [W-1:0]  r2_a;
  logic                 r2_sl;
  logic                 r2_sr;
  logic                 r2_err;
  logic                 r2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_prod  <= '0;
      r2_a     <= '0;
      r2_sl    <= 1'b0;
      r2_sr    <= 1'b0;
      r2_err   <= 1'b0;
      r2_valid <= 1'b0;
    end else begin
      r2_prod  <= w_prod;
      r2_a     <= r1_a;
      r2_sl    <= r1_sl;
      r2_sr    <= r1_sr;
      r2_err   <= r1_err;
      r2_valid <= r1_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: add, saturate, de-normalise
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] w_prod_sh;
  logic signed [PW:0]   w_lin_wide;
  logic signed [W-1:0]  w_lin;
  logic signed [W-1:0]  w_y;

  // Arithmetic shift of a signed value floors toward -inf.
  assign w_prod_sh  = r2_prod >>> FW;
  assign w_lin_wide = (PW + 1)'(r2_a) + (PW + 1)'(w_prod_sh);

  always_comb begin
    w_lin = w_lin_wide[W-1:0];
    // Out of range when the bits above the W-bit sign are not all sign copies.
    if (w_lin_wide[PW:W-1] != {(PW - W + 2){w_lin_wide[PW]}}) begin
      w_lin = w_lin_wide[PW] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
    end
  end

  always_comb begin
    w_y = w_lin;
    if (r2_sl) begin
      w_y = {w_lin[W-1], w_lin[W-1:1]};
    end else if (r2_sr) begin
      if (w_lin[W-1] != w_lin[W-2]) begin
        w_y = w_lin[W-1] ? {1'b1, {(W - 1){1'b0}}} : {1'b0, {(W - 1){1'b1}}};
      end else begin
        w_y = {w_lin[W-2:0], 1'b0};
      end
    end
  end

  logic signed [W-1:0] r_y;
  logic                r_valid;
  logic                r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_y     <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_y     <= w_y;
      r_valid <= r2_valid;
      r_err   <= r2_err;
    end
  end

  assign y_o     = r_y;
  assign valid_o = r_valid;
  assign err_o   = r_err;

endmodule

// File: tb/tb_pwl_approx.sv
module tb_pwl_approx;

  localparam int W        = 8;
  localparam int SEG_BITS = 3;

  logic                       clk;
  logic                       rst;
  logic                       valid_i;
  logic signed [W-1:0]        x_scaled_i;
  logic                       shift_l_i;
  logic                       shift_r_i;
  logic                       no_shift_i;
  logic                       coef_we;
  logic        [SEG_BITS-1:0] coef_addr;
  logic signed [W-1:0]        coef_a;
  logic signed [W-1:0]        coef_b;
  logic signed [W-1:0]        y_o;
  logic                       valid_o;
  logic                       err_o;

  pwl_approx #(.W(W), .SEG_BITS(SEG_BITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .x_scaled_i (x_scaled_i),
    .shift_l_i  (shift_l_i),
    .shift_r_i  (shift_r_i),
    .no_shift_i (no_shift_i),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_a     (coef_a),
    .coef_b     (coef_b),
    .y_o        (y_o),
    .valid_o    (valid_o),
    .err_o      (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int y;
    bit err;
    int cyc;
    string name;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: compare whenever the DUT presents a result.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        if (q.size() == 0) begin
          chk("unexpected_valid_o", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, "_y"}, int'(y_o), e.y);
          chk({e.name, "_err"}, int'(err_o), int'(e.err));
          chk({e.name, "_latency"}, cyc - e.cyc, 3);
        end
      end else if (q.size() > 0 && (cyc - q[0].cyc) >= 3) begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_missing_valid_o"}, 0, 1);
      end
    end
  end

  task automatic idle();
    valid_i = 1'b0;
    coef_we = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [SEG_BITS-1:0] addr, input int a, input int b);
    valid_i   = 1'b0;
    coef_we   = 1'b1;
    coef_addr = addr;
    coef_a    = W'(a);
    coef_b    = W'(b);
    @(posedge clk);
    #1;
    coef_we = 1'b0;
  endtask

  // Flags are {shift_l, shift_r, no_shift}. Caller may preset a same-cycle write.
  task automatic issue(input string name, input logic [7:0] x, input logic [2:0] fl,
                       input int ey, input bit eerr, input bit push);
    valid_i    = 1'b1;
    x_scaled_i = x;
    {shift_l_i, shift_r_i, no_shift_i} = fl;
    if (push) q.push_back('{y: ey, err: eerr, cyc: cyc, name: name});
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  localparam logic [2:0] FlL = 3'b100;
  localparam logic [2:0] FlR = 3'b010;
  localparam logic [2:0] FlN = 3'b001;

  initial begin
    rst        = 1'b1;
    valid_i    = 1'b0;
    x_scaled_i = '0;
    {shift_l_i, shift_r_i, no_shift_i} = 3'b001;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_a     = '0;
    coef_b     = '0;
    #2;
    chk("reset_y_o", int'(y_o), 0);
    chk("reset_valid_o", int'(valid_o), 0);
    chk("reset_err_o", int'(err_o), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();

    // Basic evaluation: seg1 a=20 b=32, x=0x30 -> frac 16 -> lin 36.
    wr(3'd1, 20, 32);
    issue("basic_n", 8'h30, FlN, 36, 1'b0, 1'b1);
    issue("basic_l", 8'h30, FlL, 18, 1'b0, 1'b1);
    issue("basic_r", 8'h30, FlR, 72, 1'b0, 1'b1);
    drain();

    // Saturation: 120 + (127*31>>>5 = 123) = 243 -> 127.
    wr(3'd1, 120, 127);
    issue("sat_n", 8'h3F, FlN, 127, 1'b0, 1'b1);
    issue("sat_r", 8'h3F, FlR, 127, 1'b0, 1'b1);
    issue("sat_l", 8'h3F, FlL, 63, 1'b0, 1'b1);
    drain();

    // Negative segment: seg5 a=-100 b=0.
    wr(3'd5, -100, 0);
    issue("neg_n", 8'hA0, FlN, -100, 1'b0, 1'b1);
    issue("neg_l", 8'hA0, FlL, -50, 1'b0, 1'b1);
    issue("neg_r", 8'hA0, FlR, -128, 1'b0, 1'b1);
    // Floor of negative product: seg6 a=10 b=-3, frac 5 -> -15>>>5 = -1 -> 9.
    wr(3'd6, 10, -3);
    issue("floor_n", 8'hC5, FlN, 9, 1'b0, 1'b1);
    // Negative saturation: seg7 a=-100 b=-128, frac 31 -> -124 -> -224 -> -128.
    wr(3'd7, -100, -128);
    issue("negsat_n", 8'hFF, FlN, -128, 1'b0, 1'b1);
    issue("negsat_l", 8'hFF, FlL, -64, 1'b0, 1'b1);
    drain();

    // Streaming with a same-edge write to seg1.
    wr(3'd1, 20, 32);
    issue("st0", 8'hA0, FlN, -100, 1'b0, 1'b1);
    issue("st1", 8'h30, FlN, 36, 1'b0, 1'b1);
    coef_we   = 1'b1;
    coef_addr = 3'd1;
    coef_a    = 8'sd0;
    coef_b    = 8'sd32;
    issue("st2_old_coef", 8'h30, FlN, 36, 1'b0, 1'b1);
    issue("st3_new_coef", 8'h30, FlN, 16, 1'b0, 1'b1);
    issue("st4", 8'h28, FlN, 8, 1'b0, 1'b1);
    issue("st5", 8'hA4, FlN, -100, 1'b0, 1'b1);
    issue("st6", 8'h00, FlN, 0, 1'b0, 1'b1);
    issue("st7", 8'h30, FlL, 8, 1'b0, 1'b1);
    drain();

    // Error flags: result as for no_shift.
    issue("err_000", 8'h30, 3'b000, 16, 1'b1, 1'b1);
    issue("err_110", 8'h30, 3'b110, 16, 1'b1, 1'b1);
    issue("err_ok", 8'h30, FlL, 8, 1'b0, 1'b1);
    drain();

    // Reset mid-stream: two samples in flight are discarded.
    issue("flight0", 8'h3F, FlN, 0, 1'b0, 1'b0);
    issue("flight1", 8'hA0, FlN, 0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid_o", int'(valid_o), 0);
    chk("midrst_y_o", int'(y_o), 0);
    chk("midrst_err_o", int'(err_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    issue("post_rst_seg1", 8'h30, FlN, 0, 1'b0, 1'b1);
    issue("post_rst_seg5", 8'hA0, FlR, 0, 1'b0, 1'b1);
    issue("post_rst_seg7", 8'hFF, FlN, 0, 1'b0, 1'b1);
    drain();
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
